// File: rtl/cva6_ras_stack.sv
// rtl/cva6_ras_stack.sv - circular return-address stack with snapshot/restore and flush
//
// Purpose: predicts return addresses for the frontend. Calls push the return
// address, returns pop it, and the top entry is presented combinationally.
// One snapshot of (top pointer, occupancy) can be saved and restored to repair
// the stack after a mispredict. Entry contents are never repaired.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_bp_i          invalidate all entries (occupancy and pointer to 0)
//   push_i, data_i      push a return address
//   pop_i               pop the top entry
//   snapshot_i          save the current top pointer and occupancy
//   restore_i           reload top pointer and occupancy from the snapshot
//   top_valid_o         occupancy != 0
//   top_addr_o          entry at the top pointer
//   empty_o, full_o     occupancy == 0 / occupancy == DEPTH
//
// Optional feature (macro CVA6_RAS_STATS_EN): adds saturating 16-bit counters
//   ovf_cnt_o           push-only while full (oldest entry overwritten)
//   udf_cnt_o           pop-only while empty
// The counters are cleared only by reset.

module cva6_ras_stack #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_bp_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [VLEN-1:0] data_i,
    input  logic            snapshot_i,
    input  logic            restore_i,
    output logic            top_valid_o,
    output logic [VLEN-1:0] top_addr_o,
    output logic            empty_o,
    output logic            full_o
`ifdef CVA6_RAS_STATS_EN
    ,
    output logic [15:0]     ovf_cnt_o,
    output logic [15:0]     udf_cnt_o
`endif
);

    localparam int unsigned TPW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic [VLEN-1:0] mem [DEPTH];
    logic [TPW-1:0]  tp;
    logic [CNTW-1:0] cnt;
    logic [TPW-1:0]  snap_tp;
    logic [CNTW-1:0] snap_cnt;

    logic [TPW-1:0]  tp_inc;
    logic [TPW-1:0]  tp_dec;
    logic            is_empty;
    logic            is_full;
    logic            do_push;
    logic            do_replace;
    logic            do_pop;

    // Modular pointer arithmetic that also works for non-power-of-two depths;
    // with DEPTH == 1 both collapse to the constant 0.
    assign tp_inc = (tp == TPW'(DEPTH - 1)) ? '0 : tp + TPW'(1);
    assign tp_dec = (tp == '0) ? TPW'(DEPTH - 1) : tp - TPW'(1);

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNTW'(DEPTH));

    // Push+pop together replaces the top in place (tail call); on an empty
    // stack there is nothing to replace, so it behaves as a plain push.
    assign do_push    = push_i && (!pop_i || is_empty);
    assign do_replace = push_i && pop_i && !is_empty;
    assign do_pop     = pop_i && !push_i && !is_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tp       <= '0;
            cnt      <= '0;
            snap_tp  <= '0;
            snap_cnt <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (flush_bp_i) begin
                tp  <= '0;
                cnt <= '0;
            end else if (restore_i) begin
                tp  <= snap_tp;
                cnt <= snap_cnt;
            end else if (do_push) begin
                tp          <= tp_inc;
                mem[tp_inc] <= data_i;
                if (!is_full) begin
                    cnt <= cnt + CNTW'(1);
                end
            end else if (do_replace) begin
                mem[tp] <= data_i;
            end else if (do_pop) begin
                tp  <= tp_dec;
                cnt <= cnt - CNTW'(1);
            end

            // Snapshot sees pre-update values; a flush in the same cycle
            // leaves an empty snapshot so a later restore cannot resurrect
            // flushed entries.
            if (snapshot_i && !restore_i) begin
                snap_tp  <= tp;
                snap_cnt <= cnt;
            end
            if (flush_bp_i) begin
                snap_cnt <= '0;
            end
        end
    end

`ifdef CVA6_RAS_STATS_EN
    logic [15:0] ovf_cnt;
    logic [15:0] udf_cnt;

    // Only pushes/pops that actually take effect are counted; flush and
    // restore suppress push/pop in their cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else if (!flush_bp_i && !restore_i) begin
            if (push_i && !pop_i && is_full && (ovf_cnt != 16'hffff)) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
            if (pop_i && !push_i && is_empty && (udf_cnt != 16'hffff)) begin
                udf_cnt <= udf_cnt + 16'd1;
            end
        end
    end

    assign ovf_cnt_o = ovf_cnt;
    assign udf_cnt_o = udf_cnt;
`endif

    assign top_addr_o  = mem[tp];
    assign top_valid_o = !is_empty;
    assign empty_o     = is_empty;
    assign full_o      = is_full;

endmodule

// File: tb/tb_cva6_ras_stack.sv
// tb/tb_cva6_ras_stack.sv - self-checking bench for cva6_ras_stack
module tb_cva6_ras_stack;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_bp;
    logic        push;
    logic        pop;
    logic [31:0] data;
    logic        snapshot;
    logic        restore;
    logic        top_valid;
    logic [31:0] top_addr;
    logic        empty;
    logic        full;
`ifdef CVA6_RAS_STATS_EN
    logic [15:0] ovf_cnt;
    logic [15:0] udf_cnt;
`endif

    cva6_ras_stack #(.DEPTH(D), .VLEN(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_bp_i  (flush_bp),
        .push_i      (push),
        .pop_i       (pop),
        .data_i      (data),
        .snapshot_i  (snapshot),
        .restore_i   (restore),
        .top_valid_o (top_valid),
        .top_addr_o  (top_addr),
        .empty_o     (empty),
        .full_o      (full)
`ifdef CVA6_RAS_STATS_EN
        ,
        .ovf_cnt_o   (ovf_cnt),
        .udf_cnt_o   (udf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a ring of D slots, an integer top index and an
    // integer occupancy, updated from the behavioural rules directly.
    logic [31:0] m_mem [D];
    int m_tp, m_cnt, m_stp, m_scnt, m_ovf, m_udf;

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_tp = 0; m_cnt = 0; m_stp = 0; m_scnt = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic model_step(input logic f, input logic pu, input logic po,
                              input logic [31:0] d, input logic sn, input logic rs);
        int old_tp, old_cnt;
        old_tp  = m_tp;
        old_cnt = m_cnt;
        if (f) begin
            m_tp = 0;
            m_cnt = 0;
        end else if (rs) begin
            m_tp  = m_stp;
            m_cnt = m_scnt;
        end else if (pu && (!po || old_cnt == 0)) begin
            if (!po && old_cnt == D && m_ovf < 65535) m_ovf++;
            m_tp = (old_tp + 1) % D;
            m_mem[m_tp] = d;
            if (old_cnt < D) m_cnt = old_cnt + 1;
        end else if (pu && po) begin
            m_mem[old_tp] = d;
        end else if (po) begin
            if (old_cnt > 0) begin
                m_tp  = (old_tp + D - 1) % D;
                m_cnt = old_cnt - 1;
            end else if (m_udf < 65535) begin
                m_udf++;
            end
        end
        if (sn && !rs) begin
            m_stp  = old_tp;
            m_scnt = old_cnt;
        end
        if (f) m_scnt = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".top_valid"}, 64'(top_valid), 64'(m_cnt != 0));
        check({tag, ".top_addr"},  64'(top_addr),  64'(m_mem[m_tp]));
        check({tag, ".empty"},     64'(empty),     64'(m_cnt == 0));
        check({tag, ".full"},      64'(full),      64'(m_cnt == D));
`ifdef CVA6_RAS_STATS_EN
        check({tag, ".ovf_cnt"},   64'(ovf_cnt),   64'(m_ovf));
        check({tag, ".udf_cnt"},   64'(udf_cnt),   64'(m_udf));
`endif
    endtask

    task automatic cyc(input string tag, input logic f, input logic pu, input logic po,
                       input logic [31:0] d, input logic sn, input logic rs);
        @(negedge clk);
        flush_bp = f; push = pu; pop = po; data = d; snapshot = sn; restore = rs;
        model_step(f, pu, po, d, sn, rs);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        flush_bp = 0; push = 0; pop = 0; data = '0; snapshot = 0; restore = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.top_valid", 64'(top_valid), 64'd0);
        check("reset.top_addr",  64'(top_addr),  64'd0);
        check("reset.empty",     64'(empty),     64'd1);
        check("reset.full",      64'(full),      64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic push/pop
        cyc("push1", 0, 1, 0, 32'h100, 0, 0);
        cyc("push2", 0, 1, 0, 32'h200, 0, 0);
        check("basic.top", 64'(top_addr), 64'h200);
        check("basic.full", 64'(full), 64'd1);
        cyc("pop1", 0, 0, 1, '0, 0, 0);
        check("basic.pop_top", 64'(top_addr), 64'h100);
        cyc("pop2", 0, 0, 1, '0, 0, 0);
        check("basic.empty", 64'(empty), 64'd1);

        // Overflow wraps over the oldest entry
        cyc("ovf1", 0, 1, 0, 32'h100, 0, 0);
        cyc("ovf2", 0, 1, 0, 32'h200, 0, 0);
        cyc("ovf3", 0, 1, 0, 32'h300, 0, 0);
        check("ovf.top", 64'(top_addr), 64'h300);
        check("ovf.full", 64'(full), 64'd1);
`ifdef CVA6_RAS_STATS_EN
        check("ovf.ovf_cnt", 64'(ovf_cnt), 64'd1);
`endif
        cyc("ovf_pop1", 0, 0, 1, '0, 0, 0);
        check("ovf.pop_top", 64'(top_addr), 64'h200);
        cyc("ovf_pop2", 0, 0, 1, '0, 0, 0);
        check("ovf.empty", 64'(empty), 64'd1);

        // Tail call: push+pop replaces top in place
        cyc("tc_push", 0, 1, 0, 32'h100, 0, 0);
        cyc("tc_pp", 0, 1, 1, 32'h444, 0, 0);
        check("tail.top", 64'(top_addr), 64'h444);
        check("tail.one", 64'({top_valid, full}), 64'b10);
        cyc("tc_flush", 1, 0, 0, '0, 0, 0);
        cyc("tc_pp_empty", 0, 1, 1, 32'h444, 0, 0);
        check("tail_empty.top", 64'(top_addr), 64'h444);
        check("tail_empty.one", 64'({top_valid, full}), 64'b10);

        // Snapshot / restore
        cyc("sn_flush", 1, 0, 0, '0, 0, 0);
        cyc("sn_push", 0, 1, 0, 32'h100, 0, 0);
        cyc("sn_take", 0, 0, 0, '0, 1, 0);
        cyc("sn_push2", 0, 1, 0, 32'h200, 0, 0);
        cyc("sn_restore", 0, 0, 0, '0, 0, 1);
        check("restore.top", 64'(top_addr), 64'h100);
        check("restore.one", 64'({top_valid, full}), 64'b10);
        cyc("sn_restore_push", 0, 1, 0, 32'h999, 0, 1);
        check("restore_push.top", 64'(top_addr), 64'h100);

        // Underflow and flush-with-push
        cyc("udf_flush", 1, 0, 0, '0, 0, 0);
        cyc("udf_pop", 0, 0, 1, '0, 0, 0);
        check("udf.top_valid", 64'(top_valid), 64'd0);
`ifdef CVA6_RAS_STATS_EN
        check("udf.udf_cnt", 64'(udf_cnt), 64'd1);
`endif
        cyc("fl_push0", 0, 1, 0, 32'h abc, 0, 0);
        cyc("fl_push", 1, 1, 0, 32'h555, 0, 0);
        check("flush_push.empty", 64'(empty), 64'd1);

        // Asynchronous reset in the middle of a push
        cyc("rp_push", 0, 1, 0, 32'h777, 0, 0);
        @(negedge clk);
        push = 1; data = 32'h888;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid.top_valid", 64'(top_valid), 64'd0);
        check("rst_mid.top_addr",  64'(top_addr),  64'd0);
        check("rst_mid.empty",     64'(empty),     64'd1);
        check("rst_mid.full",      64'(full),      64'd0);
        model_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic f, pu, po, sn, rs;
            logic [31:0] d;
            f  = ($urandom_range(0, 24) == 0);
            rs = ($urandom_range(0, 9) == 0);
            sn = ($urandom_range(0, 5) == 0);
            pu = ($urandom_range(0, 1) == 0);
            po = ($urandom_range(0, 2) == 0);
            d  = $urandom();
            cyc("rand", f, pu, po, d, sn, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
